// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: funct codes,
// FSM state encoding and the operation kind handed to the arithmetic unit.
package md_pkg;

    // R-type funct codes of the MD-class instructions
    localparam logic [5:0] MD_MULT  = 6'b011000;
    localparam logic [5:0] MD_MULTU = 6'b011001;
    localparam logic [5:0] MD_DIV   = 6'b011010;
    localparam logic [5:0] MD_DIVU  = 6'b011011;
    localparam logic [5:0] MD_MFHI  = 6'b010000;
    localparam logic [5:0] MD_MTHI  = 6'b010001;
    localparam logic [5:0] MD_MFLO  = 6'b010010;
    localparam logic [5:0] MD_MTLO  = 6'b010011;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_e;

    function automatic logic is_div_op(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational 64-bit multiply/divide result {HI,LO} for the latched operation.
// The divider exists only when the build defines MD_DIV_EN; otherwise the
// divide kinds yield zero (the controller never starts them in that build).
module md_alu
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

`ifdef MD_DIV_EN
    // Signed divide is done on magnitudes so that 0x80000000 / -1 needs no
    // special case: |a| = 0x80000000 as unsigned, quotient stays 0x80000000.
    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign signed_op = (op == OP_DIV);
    assign a_mag  = (signed_op && a[31]) ? -a : a;
    assign b_mag  = (signed_op && b[31]) ? -b : b;
    // A zero divisor result is discarded by the controller; avoid the X.
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    // Quotient truncates toward zero, remainder follows the dividend sign
    assign quot   = (signed_op && (a[31] ^ b[31])) ? -q_mag : q_mag;
    assign rem    = (signed_op && a[31]) ? -r_mag : r_mag;
`endif

    // Select the result for the requested operation kind
    always_comb begin
        // NOTE: default assignment first so every path drives result and no latch is inferred.
        result = prod_u;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
`ifdef MD_DIV_EN
            OP_DIV,
            OP_DIVU:  result = {rem, quot};
`else
            OP_DIV,
            OP_DIVU:  result = '0;
`endif
            default:  result = prod_u;
        endcase
    end

endmodule

// File: rtl/md_controller.sv
// Multiply/divide sequencer for the Execute stage: decodes MD instructions in E,
// runs a fixed-latency busy window, holds HI/LO and requests Decode stalls.
// Optional feature: define MD_DIV_EN to support div/divu; without it they are no-ops.
module md_controller
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_E,
    input  logic [31:0] SrcA,
    input  logic [31:0] rt_value,
    input  logic        md_use_D,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    md_state_e   state;
    logic [4:0]  cnt;
    md_op_e      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] alu_result;

    logic        is_r;
    logic [5:0]  funct;
    logic        dec_start;
    md_op_e      dec_op;
    logic        dec_mthi;
    logic        dec_mtlo;
    logic        start;
    logic        unused_instr_bits;

    assign is_r  = (Instr_E[31:26] == 6'b0);
    assign funct = Instr_E[5:0];
    assign unused_instr_bits = ^Instr_E[25:6];

    // Decode the MD-class instruction currently in Execute
    always_comb begin
        dec_start = 1'b0;
        dec_op    = OP_MULT;
        dec_mthi  = 1'b0;
        dec_mtlo  = 1'b0;
        if (is_r) begin
            case (funct)
                MD_MULT:  begin dec_start = 1'b1; dec_op = OP_MULT;  end
                MD_MULTU: begin dec_start = 1'b1; dec_op = OP_MULTU; end
`ifdef MD_DIV_EN
                MD_DIV:   begin dec_start = 1'b1; dec_op = OP_DIV;   end
                MD_DIVU:  begin dec_start = 1'b1; dec_op = OP_DIVU;  end
`endif
                MD_MTHI:  dec_mthi = 1'b1;
                MD_MTLO:  dec_mtlo = 1'b1;
                default:  ;
            endcase
        end
    end

    assign start    = dec_start && (state == MD_IDLE);
    assign md_stall = md_use_D && (start || md_busy);

    // mfhi/mflo read port straight from the architectural registers
    always_comb begin
        md_rdata = 32'b0;
        if (is_r && funct == MD_MFHI) md_rdata = HI;
        if (is_r && funct == MD_MFLO) md_rdata = LO;
    end

    md_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // Sequencer FSM: operand latch, busy countdown and HI/LO update
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: every register here, HI/LO included, is cleared by reset so an aborted operation leaves zeros.
        if (!reset) begin
            state   <= MD_IDLE;
            cnt     <= 5'd0;
            op_q    <= OP_MULT;
            a_q     <= 32'b0;
            b_q     <= 32'b0;
            md_busy <= 1'b0;
            HI      <= 32'b0;
            LO      <= 32'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates take the pre-edge values.
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q    <= dec_op;
                        a_q     <= SrcA;
                        b_q     <= rt_value;
                        cnt     <= is_div_op(dec_op) ? DIV_LOAD : MULT_LOAD;
                        md_busy <= 1'b1;
                        state   <= MD_BUSY;
                    end else if (dec_mthi) begin
                        HI <= SrcA;
                    end else if (dec_mtlo) begin
                        LO <= SrcA;
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        md_busy <= 1'b0;
                        state   <= MD_IDLE;
                        // A zero divisor still burns the window but keeps HI/LO
                        if (!(is_div_op(op_q) && b_q == 32'b0)) begin
                            HI <= alu_result[63:32];
                            LO <= alu_result[31:0];
                        end
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_controller.sv
// Self-checking bench for md_controller: a table of mult/div vectors checked
// through a scoreboard queue, plus hand-written stall, mthi, restart and reset sequences.
module tb_md_controller;
    import md_pkg::*;

`ifdef MD_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr_E = 32'b0;
    logic [31:0] SrcA = 32'b0;
    logic [31:0] rt_value = 32'b0;
    logic        md_use_D = 1'b0;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    md_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .Instr_E  (Instr_E),
        .SrcA     (SrcA),
        .rt_value (rt_value),
        .md_use_D (md_use_D),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .md_rdata (md_rdata),
        .HI       (HI),
        .LO       (LO)
    );

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] last_hi = 32'b0;
    logic [31:0] last_lo = 32'b0;

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {26'b0, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: scoreboard empty, got HI=0x%08h LO=0x%08h", name, HI, LO);
        end else begin
            e = sb.pop_front();
            check({name, " HI"}, HI, e.hi);
            check({name, " LO"}, LO, e.lo);
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    task automatic run_op(input vec_t v, input string name);
        int n;
        @(negedge clk);
        Instr_E  = rtype(v.funct);
        SrcA     = v.a;
        rt_value = v.b;
        md_use_D = 1'b0;
        sb.push_back('{hi: v.hi, lo: v.lo});
        @(negedge clk);
        Instr_E = 32'b0;
        #1;
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({name, " busy cycles"}, n, v.busy);
        pop_check(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // ---------------- vector table ----------------
        vecs.push_back('{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5});
        vecs.push_back('{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5});
        vecs.push_back('{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5});
        vecs.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5});
        vecs.push_back('{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 5});
`ifdef MD_DIV_EN
        vecs.push_back('{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        vecs.push_back('{MD_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        vecs.push_back('{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
        vecs.push_back('{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10});
        vecs.push_back('{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10});
`else
        vecs.push_back('{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'h80000001, 0});
        vecs.push_back('{MD_DIVU,  32'd100,      32'd7,        32'hFFFFFFFF, 32'h80000001, 0});
`endif

        // ---------------- reset state ----------------
        Instr_E  = rtype(MD_MFHI);
        md_use_D = 1'b1;
        #12;
        check("reset md_busy", 32'(md_busy), 32'd0);
        check("reset md_stall", 32'(md_stall), 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        check("reset md_rdata", md_rdata, 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        Instr_E  = 32'b0;
        md_use_D = 1'b0;

        // ---------------- table-driven ops ----------------
        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // ---------------- div in E with md_use_D ----------------
        @(negedge clk);
        Instr_E  = rtype(MD_DIV);
        SrcA     = 32'd50;
        rt_value = 32'd5;
        md_use_D = 1'b1;
        #1;
        check("div start stall", 32'(md_stall), 32'(DIV_ON));
        @(negedge clk);
        Instr_E  = 32'b0;
        md_use_D = 1'b0;
        #1;
        check("div busy", 32'(md_busy), 32'(DIV_ON));
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (DIV_ON) begin
            sb.push_back('{hi: 32'd0, lo: 32'd10});
        end else begin
            sb.push_back('{hi: last_hi, lo: last_lo});
        end
        pop_check("div use_D");

        // ---------------- mult followed by mfhi: stall window ----------------
        @(negedge clk);
        Instr_E  = rtype(MD_MULT);
        SrcA     = 32'h00010000;
        rt_value = 32'h00030000;
        md_use_D = 1'b1;
        sb.push_back('{hi: 32'h00000003, lo: 32'h00000000});
        #1;
        n = 0;
        while (md_stall && n < 40) begin
            n++;
            @(negedge clk);
            Instr_E = 32'b0;
            #1;
        end
        check("mult->mfhi stall cycles", n, 32'd6);
        Instr_E  = rtype(MD_MFHI);
        md_use_D = 1'b0;
        #1;
        check("mfhi in E stall", 32'(md_stall), 32'd0);
        if (sb.size() != 0) check("mfhi rdata", md_rdata, sb[0].hi);
        pop_check("mult->mfhi");

        // ---------------- mthi/mtlo then mfhi/mflo: no stall ----------------
        @(negedge clk);
        Instr_E  = rtype(MD_MTHI);
        SrcA     = 32'h12345678;
        md_use_D = 1'b1;
        #1;
        check("mthi stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        Instr_E  = rtype(MD_MFHI);
        md_use_D = 1'b0;
        #1;
        check("mthi->mfhi rdata", md_rdata, 32'h12345678);
        @(negedge clk);
        Instr_E  = rtype(MD_MTLO);
        SrcA     = 32'hCAFEF00D;
        md_use_D = 1'b1;
        #1;
        check("mtlo stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        Instr_E  = rtype(MD_MFLO);
        md_use_D = 1'b0;
        #1;
        check("mtlo->mflo rdata", md_rdata, 32'hCAFEF00D);
        check("mthi kept HI", HI, 32'h12345678);

        // ---------------- non-MD instructions ----------------
        @(negedge clk);
        Instr_E  = 32'h00221820;
        md_use_D = 1'b1;
        #1;
        check("add stall", 32'(md_stall), 32'd0);
        check("add rdata", md_rdata, 32'd0);
        @(negedge clk);
        Instr_E = 32'h8C000018;
        #1;
        check("lw stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        Instr_E  = 32'b0;
        md_use_D = 1'b0;
        #1;
        check("lw no busy", 32'(md_busy), 32'd0);

        // ---------------- MD in E while busy does not restart ----------------
        @(negedge clk);
        Instr_E  = rtype(MD_MULT);
        SrcA     = 32'h10;
        rt_value = 32'h10;
        sb.push_back('{hi: 32'd0, lo: 32'h100});
        @(negedge clk);
        SrcA     = 32'd3;
        rt_value = 32'd3;
        #1;
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        Instr_E = 32'b0;
        check("no-restart busy cycles", n, 32'd5);
        pop_check("no-restart");

        // ---------------- reset during third busy cycle ----------------
        @(negedge clk);
        Instr_E  = DIV_ON ? rtype(MD_DIV) : rtype(MD_MULT);
        SrcA     = 32'hFFFFFFF9;
        rt_value = 32'd2;
        @(negedge clk);
        Instr_E = 32'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre-reset busy", 32'(md_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort md_busy", 32'(md_busy), 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op('{MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 5}, "post-reset mult");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/md_controller.md
# md_controller

Multiply/divide sequencer for the Execute stage of the 5-stage pipeline. It decodes MD-class instructions in E and holds the HI/LO registers. It runs a fixed-latency busy window per multiply or divide and raises a stall request so that dependent MD instructions wait in Decode. Operands come from the already-forwarded SrcA and rt_value of the Execute stage, and results reach the pipeline through mfhi/mflo.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (1..31).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (1..31).
- `clk` input 1: pipeline clock; all state on the rising edge.
- `reset` input 1: reset, asynchronous and active-low; clears all state.
- `Instr_E` input 32: instruction currently in Execute.
- `SrcA` input 32: forwarded rs value in E.
- `rt_value` input 32: forwarded rt value in E.
- `md_use_D` input 1: instruction in Decode is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `md_busy` output 1: multiply/divide in progress.
- `md_stall` output 1: freeze PC/F/D and bubble E.
- `md_rdata` output 32: HI for mfhi in E, LO for mflo in E, else 0.
- `HI`, `LO` output 32 each: architectural registers.

## Operation
- Decode only when `Instr_E[31:26]==0`. Funct values: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. All other funct values are no-ops.
- `start` = E holds mult/multu/div/divu AND state IDLE. This is internal and combinational.
- States:
  - IDLE: on `start`, latch the op and both operands, load the counter with MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - BUSY: decrement the counter each edge. At the edge where the counter reaches 1, write HI/LO and go to IDLE.
- mult: signed 32×32 to 64-bit product. multu: unsigned. Write {HI,LO} = product.
- div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. divu: unsigned.
- Divide by zero: HI and LO are left unchanged, but the busy window still runs in full.
- 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mthi/mtlo in E while IDLE: HI or LO takes `SrcA` at the end of that cycle. If the state is BUSY the write is ignored; the stall guarantees this never occurs in legal flow.
- An MD instruction in E while BUSY does not restart the unit.
- `md_stall` = `md_use_D` & (`start` | `md_busy`).
- `md_rdata` is combinational from the current HI/LO.

## Timing
- Reset value of every output is 0, state is IDLE, and the counter is 0. An asynchronous reset during BUSY aborts the operation and leaves HI/LO=0.
- A mult that is in E during cycle t produces `md_busy`=1 for cycles t+1 .. t+MULT_CYCLES. The new HI/LO is visible in cycle t+MULT_CYCLES+1.
- A mfhi that immediately follows a mult stalls in D for cycles t .. t+MULT_CYCLES. It enters E at t+MULT_CYCLES+1 and reads the new HI.
- Back-to-back MD operations: the second one enters E on the first cycle after `md_busy` falls, which is exactly when it may start.
- mthi followed by mfhi: no stall; the write lands at the end of the mthi cycle.
- Non-MD instructions never stall because of this block.

## Configuration
- `MD_DIV_EN`, when defined: div/divu are supported as described above.
- When not defined: div/divu decode as no-ops, with no busy window, no stall and HI/LO unchanged. `DIV_CYCLES` is ignored and no divider logic is synthesized.

## Structure
- Shared package `md_pkg` holds:
  - the funct constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MTHI, MD_MFLO, MD_MTLO);
  - the state encoding (MD_IDLE, MD_BUSY);
  - the op-kind enum.
- Sub-module `md_alu`: combinational 64-bit result from op-kind, a and b. Divider instantiation inside it is guarded by `MD_DIV_EN`. The controller holds the FSM, counter, operand latches and HI/LO.

## Test plan
- mult with SrcA=0xFFFFFFFE, rt=3. Required: md_busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with multu give HI=0x00000002, LO=0xFFFFFFFA.
- div with SrcA=-7, rt=2. Required: LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. divu with 7/0 leaves HI/LO unchanged.
- mult followed by mfhi with md_use_D=1. Required: md_stall=1 for exactly 6 cycles, and md_rdata equals the new HI once mfhi is in E.
- mthi with SrcA=0x12345678 followed by mfhi. Required: no stall, md_rdata=0x12345678.
- reset driven low during the third busy cycle of a div. Required: md_busy=0 immediately, HI=LO=0, and a new mult starts normally afterwards.
- Build without `MD_DIV_EN`: a div in E with md_use_D=1 gives md_busy=0, md_stall=0 and HI/LO unchanged.
